// File: rtl/pipe_stage_reg.sv
// Reusable pipeline boundary register carrying payload, PC and valid, with valid/ready
// back-pressure, flush, an optional skid entry and a saturating stall counter.
module pipe_stage_reg #(
  parameter int W     = 64,
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            r_m_valid;
  logic [W-1:0]    r_m_data;
  logic [XLEN-1:0] r_m_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic            w_accept;
  logic            w_drain;

  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_drain   = r_m_valid & out_ready;
  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign out_pc    = r_m_pc;
  assign stall_cnt = r_stall_cnt;

  if (SKID != 0) begin : g_skid
    logic            r_s_valid;
    logic [W-1:0]    r_s_data;
    logic [XLEN-1:0] r_s_pc;

    // Ready depends only on held state, breaking the out_ready -> in_ready path.
    assign in_ready = ~r_s_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_m_valid <= 1'b0;
        r_m_data  <= '0;
        r_m_pc    <= '0;
        r_s_valid <= 1'b0;
        r_s_data  <= '0;
        r_s_pc    <= '0;
      end else if (flush) begin
        r_m_valid <= 1'b0;
        r_s_valid <= 1'b0;
      end else if (w_drain && r_s_valid) begin
        r_m_data  <= r_s_data;
        r_m_pc    <= r_s_pc;
        r_s_valid <= 1'b0;
      end else if (w_drain) begin
        if (w_accept) begin
          r_m_data <= in_data;
          r_m_pc   <= in_pc;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (r_m_valid && w_accept) begin
        r_s_valid <= 1'b1;
        r_s_data  <= in_data;
        r_s_pc    <= in_pc;
      end else if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= in_data;
        r_m_pc    <= in_pc;
      end
    end
  end else begin : g_single
    assign in_ready = ~r_m_valid | out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_m_valid <= 1'b0;
        r_m_data  <= '0;
        r_m_pc    <= '0;
      end else if (flush) begin
        r_m_valid <= 1'b0;
      end else if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= in_data;
        r_m_pc    <= in_pc;
      end else if (w_drain) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  // Saturates at all-ones so long stalls stay visible rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (r_m_valid && !out_ready && !flush && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, single-entry and narrow-counter instances
// share one stimulus set; each task checks the instance it targets.
module tb_pipe_stage_reg;
  localparam int W = 16;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic [XLEN-1:0] in_pc;

  logic a_in_ready, a_out_valid; logic [W-1:0] a_out_data; logic [XLEN-1:0] a_out_pc; logic [15:0] a_cnt;
  logic b_in_ready, b_out_valid; logic [W-1:0] b_out_data; logic [XLEN-1:0] b_out_pc; logic [15:0] b_cnt;
  logic c_in_ready, c_out_valid; logic [W-1:0] c_out_data; logic [XLEN-1:0] c_out_pc; logic [3:0]  c_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.W(W), .XLEN(XLEN), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_pc(a_out_pc), .stall_cnt(a_cnt));

  pipe_stage_reg #(.W(W), .XLEN(XLEN), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_pc(b_out_pc), .stall_cnt(b_cnt));

  pipe_stage_reg #(.W(W), .XLEN(XLEN), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_pc(in_pc), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_pc(c_out_pc), .stall_cnt(c_cnt));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_data  = 16'h1000 + pc[15:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A5; in_pc = 32'h0000_0040;
    tick(); tick();
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else n_pass++;
    n_total++; if (a_out_data !== 16'h0) $display("FAIL reset_out_data got %h want 0", a_out_data); else n_pass++;
    n_total++; if (a_out_pc !== 32'h0) $display("FAIL reset_out_pc got %h want 0", a_out_pc); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready_skid got %b want 1", a_in_ready); else n_pass++;
    n_total++; if (b_in_ready !== 1'b1) $display("FAIL reset_in_ready_single got %b want 1", b_in_ready); else n_pass++;
    n_total++; if (a_cnt !== 16'd0) $display("FAIL reset_stall_cnt got %0d want 0", a_cnt); else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [XLEN-1:0] pcs [3];
    pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i]);
      tick();
      n_total++; if (a_out_valid !== 1'b1 || a_out_pc !== pcs[i])
        $display("FAIL stream_pc%0d got v=%b pc=%h want v=1 pc=%h", i, a_out_valid, a_out_pc, pcs[i]); else n_pass++;
    end
    n_total++; if (a_out_data !== 16'h1008) $display("FAIL stream_data got %h want 1008", a_out_data); else n_pass++;
    drive(1'b0, 32'h0);
    tick();
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL stream_drained got %b want 0", a_out_valid); else n_pass++;
    n_total++; if (a_cnt !== 16'd0) $display("FAIL stream_stall_cnt got %0d want 0", a_cnt); else n_pass++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b1;
    drive(1'b1, 32'h10); tick();
    drive(1'b1, 32'h14); tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h18); tick();
    drive(1'b0, 32'h0);
    n_total++; if (a_out_pc !== 32'h14 || a_out_valid !== 1'b1)
      $display("FAIL bp_main got v=%b pc=%h want v=1 pc=14", a_out_valid, a_out_pc); else n_pass++;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready_full got %b want 0", a_in_ready); else n_pass++;
    tick(); tick();
    n_total++; if (a_cnt !== 16'd3) $display("FAIL bp_stall_cnt got %0d want 3", a_cnt); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (a_out_pc !== 32'h18 || a_out_valid !== 1'b1 || a_out_data !== 16'h1018)
      $display("FAIL bp_skid_out got v=%b pc=%h d=%h want v=1 pc=18 d=1018", a_out_valid, a_out_pc, a_out_data); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL bp_in_ready_free got %b want 1", a_in_ready); else n_pass++;
    tick();
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL bp_no_dup got %b want 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h40); tick();
    drive(1'b1, 32'h44); tick();
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL flush_full_in_ready got %b want 0", a_in_ready); else n_pass++;
    flush = 1'b1;
    drive(1'b1, 32'h20); tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    n_total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
      $display("FAIL flush_clear got v=%b rdy=%b want v=0 rdy=1", a_out_valid, a_in_ready); else n_pass++;
    n_total++; if (a_cnt !== 16'd4) $display("FAIL flush_stall_cnt got %0d want 4", a_cnt); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (a_out_valid !== 1'b0) $display("FAIL flush_lost_%0d got v=%b pc=%h want v=0", i, a_out_valid, a_out_pc); else n_pass++;
    end
  endtask

  task automatic test_single_entry();
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h2C); tick();
    drive(1'b1, 32'h30); #1;
    n_total++; if (b_in_ready !== 1'b0) $display("FAIL single_in_ready_stall got %b want 0", b_in_ready); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL skid_in_ready_reg got %b want 1", a_in_ready); else n_pass++;
    out_ready = 1'b1; #1;
    n_total++; if (b_in_ready !== 1'b1) $display("FAIL single_in_ready_comb got %b want 1", b_in_ready); else n_pass++;
    tick();
    drive(1'b0, 32'h0);
    n_total++; if (b_out_valid !== 1'b1 || b_out_pc !== 32'h30 || b_out_data !== 16'h1030)
      $display("FAIL single_emit got v=%b pc=%h d=%h want v=1 pc=30 d=1030", b_out_valid, b_out_pc, b_out_data); else n_pass++;
    tick();
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", b_out_valid); else n_pass++;
  endtask

  task automatic test_saturation();
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h50); tick();
    drive(1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) begin
        n_total++; if (c_cnt !== 4'd14) $display("FAIL sat_mid got %0d want 14", c_cnt); else n_pass++;
      end
    end
    n_total++; if (c_cnt !== 4'd15) $display("FAIL sat_hold got %0d want 15", c_cnt); else n_pass++;
    n_total++; if (a_cnt !== 16'd20) $display("FAIL wide_cnt got %0d want 20", a_cnt); else n_pass++;
    n_total++; if (c_out_pc !== 32'h50 || c_out_valid !== 1'b1)
      $display("FAIL sat_held_pc got v=%b pc=%h want v=1 pc=50", c_out_valid, c_out_pc); else n_pass++;
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h60); tick();
    rst = 1'b0; flush = 1'b0; drive(1'b0, 32'h0);
    n_total++; if (c_cnt !== 4'd0) $display("FAIL sat_reset got %0d want 0", c_cnt); else n_pass++;
    n_total++; if (c_out_valid !== 1'b0 || c_out_pc !== 32'h0)
      $display("FAIL rst_override got v=%b pc=%h want v=0 pc=0", c_out_valid, c_out_pc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_single_entry();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
